// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, single-outstanding imem fetch, decode handshake, redirects
// Optional opcode legality flag enabled by defining IFETCH_ILLEGAL_CHECK_EN.
module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_illegal
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t          state_q;
  logic [XLEN-1:0] pc_q, instr_q, tgt_q;
  logic            req_q, valid_q, kill_q;
  logic [XLEN-1:0] target_d, pc_inc_d;
  logic            unused_tgt_bits;

  assign target_d        = {redirect_target[XLEN-1:2], 2'b00};
  assign pc_inc_d        = pc_q + XLEN'(4);
  assign unused_tgt_bits = ^redirect_target[1:0];

`ifdef IFETCH_ILLEGAL_CHECK_EN
  logic illegal_q;

  function automatic logic op_illegal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011: op_illegal = 1'b0;
      default:                                                     op_illegal = 1'b1;
    endcase
  endfunction

  assign instr_illegal = illegal_q;
`else
  assign instr_illegal = 1'b0;
`endif

  // imem_addr follows pc_q, which only moves once the outstanding response has returned
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      tgt_q   <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
`ifdef IFETCH_ILLEGAL_CHECK_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (!req_q) begin
            // one-cycle gap after a killed response; nothing is outstanding
            req_q <= 1'b1;
            if (redirect) pc_q <= target_d;
          end else if (imem_rvalid) begin
            if (redirect) begin
              pc_q   <= target_d;
              kill_q <= 1'b0;
            end else if (kill_q) begin
              kill_q <= 1'b0;
              pc_q   <= tgt_q;
              req_q  <= 1'b0;
            end else begin
              instr_q <= imem_rdata;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= HOLD;
`ifdef IFETCH_ILLEGAL_CHECK_EN
              illegal_q <= op_illegal(imem_rdata[6:0]);
`endif
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
            tgt_q  <= target_d;
          end
        end
        HOLD: begin
          if (redirect || instr_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
            pc_q    <= redirect ? target_d : pc_inc_d;
`ifdef IFETCH_ILLEGAL_CHECK_EN
            illegal_q <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign pc          = pc_q;

endmodule
